mesh_endpoint: RTL and testbench

Network endpoint attached to one router's local port in the 3x3 mesh. It packs host transmit requests into single-flit packets and drives them onto the router's `local_in` port, and it unpacks flits arriving on `local_out` into a host receive stream. It is the producer/consumer counterpart of the mesh, with one instance per node.

---
 rtl/mesh_endpoint.sv | 155 +++++++++++++++
 tb/tb_mesh_endpoint.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mesh_endpoint.sv
// mesh_endpoint: host-side endpoint on one router's local port of the 3x3 mesh.
// Packs host transmit requests into single-flit packets for local_in, paced by
// an injection FSM. Unpacks flits addressed to this node from local_out into a
// host receive FIFO, and counts dropped and misrouted flits.
// Flit layout: [7] valid, [6:5] dest row, [4:3] dest col, [2:0] payload.
module mesh_endpoint #(
  parameter int DATAWID    = 8,
  parameter int MY_ROW     = 0,
  parameter int MY_COL     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int INJ_GAP    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [1:0]         tx_dest_row,
  input  logic [1:0]         tx_dest_col,
  input  logic [2:0]         tx_payload,
  output logic [DATAWID-1:0] local_in,
  input  logic [DATAWID-1:0] local_out,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [2:0]         rx_payload,
  output logic               rx_src_ok,
  output logic [7:0]         drop_cnt,
  output logic [7:0]         misroute_cnt
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ROW      = MY_ROW[1:0];
  localparam logic [1:0] COL      = MY_COL[1:0];
  localparam logic [3:0] GAP_INIT = INJ_GAP[3:0];

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  // ---------------- TX FIFO ----------------
  logic [6:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr_ptr, tx_rd_ptr;
  logic        tx_empty, tx_full, tx_push, tx_pop;
  logic [6:0]  tx_head;

  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                    (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_head  = tx_mem[tx_rd_ptr[AW-1:0]];

  // Store host requests as {dest_row, dest_col, payload}.
  // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= {tx_dest_row, tx_dest_col, tx_payload};
  end

  // TX pointer update; reset empties the FIFO.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  // ---------------- Injection FSM ----------------
  state_t              state, state_next;
  logic [3:0]          gap_cnt, gap_next;
  logic [DATAWID-1:0]  local_in_next;

  // State, gap counter and the registered local_in flit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      gap_cnt  <= '0;
      local_in <= '0;
    end else begin
      state    <= state_next;
      gap_cnt  <= gap_next;
      local_in <= local_in_next;
    end
  end

  // Next-state logic: pop and launch in IDLE, idle flit otherwise.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_next    = state;
    gap_next      = gap_cnt;
    local_in_next = '0;
    tx_pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop        = 1'b1;
          local_in_next = DATAWID'({1'b1, tx_head});
          state_next    = S_SEND;
        end
      end
      S_SEND: begin
        gap_next   = GAP_INIT;
        state_next = (GAP_INIT == 4'd0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt <= 4'd1) state_next = S_IDLE;
        else                 gap_next   = gap_cnt - 4'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- RX path ----------------
  logic [2:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr_ptr, rx_rd_ptr;
  logic        rx_empty, rx_full, rx_pop, rx_push;
  logic        flit_valid, flit_mine, flit_drop, flit_misroute;

  assign flit_valid    = local_out[7];
  assign flit_mine     = flit_valid && (local_out[6:5] == ROW) && (local_out[4:3] == COL);
  assign flit_misroute = flit_valid && !flit_mine;

  assign rx_empty   = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full    = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                      (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
  assign rx_valid   = !rx_empty;
  assign rx_pop     = rx_valid && rx_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign rx_push    = flit_mine && (!rx_full || rx_pop);
  assign flit_drop  = flit_mine && rx_full && !rx_pop;
  assign rx_payload = rx_empty ? 3'd0 : rx_mem[rx_rd_ptr[AW-1:0]];

  // Store payloads of flits addressed to this node.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= local_out[2:0];
  end

  // RX pointers, sticky receive flag and saturating error counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr    <= '0;
      rx_rd_ptr    <= '0;
      rx_src_ok    <= 1'b0;
      drop_cnt     <= '0;
      misroute_cnt <= '0;
    end else begin
      if (rx_push)   rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (flit_mine) rx_src_ok <= 1'b1;
      if (flit_drop && drop_cnt != 8'hFF)         drop_cnt     <= drop_cnt + 8'd1;
      if (flit_misroute && misroute_cnt != 8'hFF) misroute_cnt <= misroute_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mesh_endpoint.sv
// tb_mesh_endpoint: directed bench for mesh_endpoint at node (1,1), INJ_GAP=2,
// FIFO_DEPTH=4. Inputs change 1 time unit after a rising edge and outputs are
// sampled there, well away from the next edge.
module tb_mesh_endpoint;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] tx_dest_row;
  logic [1:0] tx_dest_col;
  logic [2:0] tx_payload;
  logic [7:0] local_in;
  logic [7:0] local_out;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] rx_payload;
  logic       rx_src_ok;
  logic [7:0] drop_cnt;
  logic [7:0] misroute_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mesh_endpoint #(
    .DATAWID(8), .MY_ROW(1), .MY_COL(1), .FIFO_DEPTH(4), .INJ_GAP(2)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_dest_row(tx_dest_row), .tx_dest_col(tx_dest_col), .tx_payload(tx_payload),
    .local_in(local_in), .local_out(local_out),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_payload(rx_payload),
    .rx_src_ok(rx_src_ok), .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic bad;
    reset = 1'b1; tx_valid = 1'b0; tx_dest_row = '0; tx_dest_col = '0; tx_payload = '0;
    local_out = 8'h00; rx_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    total++; if (local_in !== 8'h00) $display("FAIL reset_local_in got %h want 00", local_in); else passed++;
    total++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b want 1", tx_ready); else passed++;
    total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", rx_valid); else passed++;
    total++; if (rx_payload !== 3'd0) $display("FAIL reset_rx_payload got %0d want 0", rx_payload); else passed++;
    total++; if (rx_src_ok !== 1'b0) $display("FAIL reset_rx_src_ok got %b want 0", rx_src_ok); else passed++;
    total++; if (drop_cnt !== 8'h00) $display("FAIL reset_drop_cnt got %h want 00", drop_cnt); else passed++;
    total++; if (misroute_cnt !== 8'h00) $display("FAIL reset_misroute_cnt got %h want 00", misroute_cnt); else passed++;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (local_in !== 8'h00) bad = 1'b1;
    end
    total++; if (bad !== 1'b0) $display("FAIL idle_local_in nonzero flit seen, want 00 for 20 cycles"); else passed++;
  endtask

  task automatic test_single_tx();
    int seen;
    tx_valid = 1'b1; tx_dest_row = 2'd2; tx_dest_col = 2'd0; tx_payload = 3'd5;
    tick();  // push edge
    tx_valid = 1'b0;
    total++; if (local_in !== 8'h00) $display("FAIL single_pre got %h want 00", local_in); else passed++;
    tick();  // load edge
    total++; if (local_in !== 8'hC5) $display("FAIL single_flit got %h want C5", local_in); else passed++;
    tick();
    total++; if (local_in !== 8'h00) $display("FAIL single_after got %h want 00", local_in); else passed++;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (local_in !== 8'h00) seen++;
    end
    total++; if (seen !== 0) $display("FAIL single_extra got %0d extra flits want 0", seen); else passed++;
  endtask

  // A leading flit A occupies the FSM so the following 4-push burst fills the FIFO.
  task automatic test_back_to_back();
    logic [1:0] rows [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1};
    logic [1:0] cols [5] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1};
    logic [2:0] pays [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [7:0] flits[5] = '{8'h81, 8'h8A, 8'hA3, 8'hD4, 8'hAF};
    logic [7:0] exp;
    for (int k = 0; k <= 20; k++) begin
      if (k < 5) begin
        tx_valid = 1'b1; tx_dest_row = rows[k]; tx_dest_col = cols[k]; tx_payload = pays[k];
      end else begin
        tx_valid = 1'b0;
      end
      tick();
      exp = ((k % 4) == 1 && k <= 17) ? flits[(k - 1) / 4] : 8'h00;
      total++;
      if (local_in !== exp) $display("FAIL burst_flit k=%0d got %h want %h", k, local_in, exp);
      else passed++;
      if (k == 4) begin
        total++; if (tx_ready !== 1'b0) $display("FAIL burst_full got %b want 0", tx_ready); else passed++;
      end
      if (k == 5) begin
        total++; if (tx_ready !== 1'b1) $display("FAIL burst_ready_back got %b want 1", tx_ready); else passed++;
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_rx_match();
    local_out = 8'h2B;  // valid bit clear: ignored
    tick();
    local_out = 8'h00;
    total++; if (rx_valid !== 1'b0) $display("FAIL rx_invalid_flit rx_valid got %b want 0", rx_valid); else passed++;
    total++; if (rx_src_ok !== 1'b0) $display("FAIL rx_invalid_src_ok got %b want 0", rx_src_ok); else passed++;
    local_out = 8'hAB;
    tick();
    local_out = 8'h00;
    total++; if (rx_valid !== 1'b1) $display("FAIL rx_match_valid got %b want 1", rx_valid); else passed++;
    total++; if (rx_payload !== 3'd3) $display("FAIL rx_match_payload got %0d want 3", rx_payload); else passed++;
    total++; if (rx_src_ok !== 1'b1) $display("FAIL rx_match_src_ok got %b want 1", rx_src_ok); else passed++;
    total++; if (misroute_cnt !== 8'h00) $display("FAIL rx_match_misroute got %h want 00", misroute_cnt); else passed++;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    total++; if (rx_valid !== 1'b0) $display("FAIL rx_match_pop got %b want 0", rx_valid); else passed++;
  endtask

  task automatic test_rx_overflow();
    logic [2:0] exp_q [4] = '{3'd2, 3'd3, 3'd4, 3'd7};
    rx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      local_out = 8'hA8 | 8'(i);
      tick();
    end
    local_out = 8'h00;
    total++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop got %0d want 2", drop_cnt); else passed++;
    total++; if (rx_payload !== 3'd1) $display("FAIL ovf_head got %0d want 1", rx_payload); else passed++;
    tick();
    total++; if (rx_payload !== 3'd1) $display("FAIL ovf_head_stable got %0d want 1", rx_payload); else passed++;
    local_out = 8'hAF; rx_ready = 1'b1;  // 7th flit with simultaneous pop
    tick();
    local_out = 8'h00; rx_ready = 1'b0;
    total++; if (drop_cnt !== 8'd2) $display("FAIL ovf_simul_drop got %0d want 2", drop_cnt); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_valid !== 1'b1 || rx_payload !== exp_q[i])
        $display("FAIL ovf_drain i=%0d got v=%b p=%0d want v=1 p=%0d", i, rx_valid, rx_payload, exp_q[i]);
      else passed++;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    total++; if (rx_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", rx_valid); else passed++;
  endtask

  task automatic test_misroute();
    local_out = 8'h90;  // dest (0,2)
    for (int i = 0; i < 254; i++) tick();
    total++; if (misroute_cnt !== 8'hFE) $display("FAIL mis_254 got %h want FE", misroute_cnt); else passed++;
    for (int i = 0; i < 46; i++) tick();
    total++; if (misroute_cnt !== 8'hFF) $display("FAIL mis_sat got %h want FF", misroute_cnt); else passed++;
    total++; if (rx_valid !== 1'b0) $display("FAIL mis_no_push got %b want 0", rx_valid); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (misroute_cnt !== 8'h00) $display("FAIL mis_reset got %h want 00", misroute_cnt); else passed++;
    total++; if (drop_cnt !== 8'h00) $display("FAIL mis_reset_drop got %h want 00", drop_cnt); else passed++;
    total++; if (rx_src_ok !== 1'b0) $display("FAIL mis_reset_src_ok got %b want 0", rx_src_ok); else passed++;
    local_out = 8'h00;
    tick();
  endtask

  task automatic test_reset_inflight();
    int seen;
    tx_valid = 1'b1; tx_dest_row = 2'd2; tx_dest_col = 2'd2; tx_payload = 3'd6;
    for (int i = 0; i < 3; i++) tick();
    tx_valid = 1'b0;
    total++; if (local_in !== 8'h00) $display("FAIL inflight_pre got %h want 00", local_in); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (local_in !== 8'h00) $display("FAIL inflight_reset_local_in got %h want 00", local_in); else passed++;
    total++; if (tx_ready !== 1'b1) $display("FAIL inflight_reset_tx_ready got %b want 1", tx_ready); else passed++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (local_in !== 8'h00) seen++;
    end
    total++; if (seen !== 0) $display("FAIL inflight_discard got %0d flits want 0", seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_back_to_back();
    test_rx_match();
    test_rx_overflow();
    test_misroute();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
